// File: rtl/sda_kernel_ap_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sda_kernel_ap_ctrl_pkg: register map, AP_CTRL bit positions, control FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package sda_kernel_ap_ctrl_pkg;

  localparam logic [1:0] REG_AP_CTRL = 2'd0;
  localparam logic [1:0] REG_GIE     = 2'd1;
  localparam logic [1:0] REG_IER     = 2'd2;
  localparam logic [1:0] REG_ISR     = 2'd3;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;
  localparam int AP_READY_BIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GO_REQ   = 3'd1,
    ST_GO_REL   = 3'd2,
    ST_RUN      = 3'd3,
    ST_DONE_ACK = 3'd4
  } ap_state_t;

endpackage

`default_nettype wire

// File: rtl/sda_kernel_irq_regs.sv
// ----------------------------------------------------------------------------
// sda_kernel_irq_regs: GIE / IER / ISR registers and the level interrupt output
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sda_kernel_irq_regs
  import sda_kernel_ap_ctrl_pkg::*;
#(
  parameter int IRQ_SRCS = 2
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                wr_en,
  input  logic [1:0]          addr,
  input  logic [IRQ_SRCS-1:0] wdata,
  input  logic [IRQ_SRCS-1:0] irq_ev,
  output logic [31:0]         rdata,
  output logic                ap_interrupt
);

  logic                r_gie;
  logic [IRQ_SRCS-1:0] r_ier;
  logic [IRQ_SRCS-1:0] r_isr;
  logic                r_irq;
  logic [IRQ_SRCS-1:0] w_isr_toggle;
  logic [IRQ_SRCS-1:0] w_isr_nxt;

  // Hardware set is OR-ed after the toggle so a coincident event always wins.
  always_comb begin
    w_isr_toggle = (wr_en && addr == REG_ISR) ? wdata : '0;
    w_isr_nxt    = (r_isr ^ w_isr_toggle) | (irq_ev & r_ier);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_gie <= 1'b0;
      r_ier <= '0;
      r_isr <= '0;
      r_irq <= 1'b0;
    end else begin
      if (wr_en && addr == REG_GIE) r_gie <= wdata[0];
      if (wr_en && addr == REG_IER) r_ier <= wdata;
      r_isr <= w_isr_nxt;
      r_irq <= r_gie & (|r_isr);
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      REG_GIE: rdata = {31'd0, r_gie};
      REG_IER: rdata = 32'(r_ier);
      REG_ISR: rdata = 32'(r_isr);
      default: rdata = '0;
    endcase
  end

  assign ap_interrupt = r_irq;

endmodule

`default_nettype wire

// File: rtl/sda_kernel_ap_ctrl_irq.sv
// ----------------------------------------------------------------------------
// sda_kernel_ap_ctrl_irq: AP_CTRL register block driving a four-phase go/done action
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sda_kernel_ap_ctrl_irq
  import sda_kernel_ap_ctrl_pkg::*;
#(
  parameter int IRQ_SRCS = 2
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        reg_req,
  output logic        reg_ack,
  input  logic        reg_write_en,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        go_0r,
  input  logic        go_0a,
  input  logic        done_0r,
  output logic        done_0a,
  output logic        ap_interrupt
);

  ap_state_t   r_state;
  ap_state_t   w_state_nxt;
  logic        r_ack;
  logic        r_served;
  logic [31:0] r_rdata;
  logic        r_ap_start;
  logic        r_ap_done;
  logic        r_ap_ready;
  logic        r_go_0r;
  logic        r_done_0a;

  logic        w_access;
  logic        w_wr;
  logic        w_rd;
  logic        w_ctrl_wr;
  logic        w_ctrl_rd;
  logic        w_ap_idle;
  logic [31:0] w_ap_ctrl;
  logic [31:0] w_irq_rdata;
  logic        w_go_0r_nxt;
  logic        w_done_0a_nxt;
  logic        w_ev_ready;
  logic        w_ev_done;

  // One access per request: r_served blocks re-acks until reg_req is seen low.
  assign w_access  = reg_req & ~r_ack & ~r_served;
  assign w_wr      = w_access & reg_write_en;
  assign w_rd      = w_access & ~reg_write_en;
  assign w_ctrl_wr = w_wr & (reg_addr == REG_AP_CTRL);
  assign w_ctrl_rd = w_rd & (reg_addr == REG_AP_CTRL);
  assign w_ap_idle = (r_state == ST_IDLE);

  always_comb begin
    w_ap_ctrl               = '0;
    w_ap_ctrl[AP_START_BIT] = r_ap_start;
    w_ap_ctrl[AP_DONE_BIT]  = r_ap_done;
    w_ap_ctrl[AP_IDLE_BIT]  = w_ap_idle;
    w_ap_ctrl[AP_READY_BIT] = r_ap_ready;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_ack    <= 1'b0;
      r_served <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_ack    <= w_access;
      r_served <= reg_req & (r_served | r_ack);
      if (w_rd) r_rdata <= (reg_addr == REG_AP_CTRL) ? w_ap_ctrl : w_irq_rdata;
      else      r_rdata <= '0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state   <= ST_IDLE;
      r_go_0r   <= 1'b0;
      r_done_0a <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_go_0r   <= w_go_0r_nxt;
      r_done_0a <= w_done_0a_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (r_ap_start) w_state_nxt = ST_GO_REQ;
      ST_GO_REQ:   if (go_0a)      w_state_nxt = ST_GO_REL;
      ST_GO_REL:   if (!go_0a)     w_state_nxt = ST_RUN;
      ST_RUN:      if (done_0r)    w_state_nxt = ST_DONE_ACK;
      ST_DONE_ACK: if (!done_0r)   w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they leave flops.
  always_comb begin
    w_go_0r_nxt   = (w_state_nxt == ST_GO_REQ);
    w_done_0a_nxt = (w_state_nxt == ST_DONE_ACK);
    w_ev_ready    = (r_state == ST_GO_REQ) & go_0a;
    w_ev_done     = (r_state == ST_DONE_ACK) & ~done_0r;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_ap_start <= 1'b0;
      r_ap_done  <= 1'b0;
      r_ap_ready <= 1'b0;
    end else begin
      if (w_ev_ready)
        r_ap_start <= 1'b0;
      else if (w_ctrl_wr && reg_wdata[AP_START_BIT] && w_ap_idle)
        r_ap_start <= 1'b1;

      if (w_ev_done)      r_ap_done <= 1'b1;
      else if (w_ctrl_rd) r_ap_done <= 1'b0;

      if (w_ev_ready)     r_ap_ready <= 1'b1;
      else if (w_ctrl_rd) r_ap_ready <= 1'b0;
    end
  end

  sda_kernel_irq_regs #(
    .IRQ_SRCS (IRQ_SRCS)
  ) u_irq_regs (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .wr_en        (w_wr),
    .addr         (reg_addr),
    .wdata        (reg_wdata[IRQ_SRCS-1:0]),
    .irq_ev       (IRQ_SRCS'({w_ev_ready, w_ev_done})),
    .rdata        (w_irq_rdata),
    .ap_interrupt (ap_interrupt)
  );

  assign reg_ack   = r_ack;
  assign reg_rdata = r_rdata;
  assign go_0r     = r_go_0r;
  assign done_0a   = r_done_0a;

endmodule

`default_nettype wire

// File: tb/tb_sda_kernel_ap_ctrl_irq.sv
// ----------------------------------------------------------------------------
// tb_sda_kernel_ap_ctrl_irq: scoreboard bench for the AP_CTRL / interrupt block
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sda_kernel_ap_ctrl_irq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        reg_req;
  logic        reg_ack;
  logic        reg_write_en;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        go_0r;
  logic        go_0a;
  logic        done_0r;
  logic        done_0a;
  logic        ap_interrupt;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 ap_clk = ~ap_clk;

  sda_kernel_ap_ctrl_irq #(
    .IRQ_SRCS (2)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .reg_req      (reg_req),
    .reg_ack      (reg_ack),
    .reg_write_en (reg_write_en),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .go_0r        (go_0r),
    .go_0a        (go_0a),
    .done_0r      (done_0r),
    .done_0a      (done_0a),
    .ap_interrupt (ap_interrupt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drives immediately; caller is away from the active edge.
  task automatic reg_xfer(input logic wr, input logic [1:0] idx, input logic [31:0] data,
                          input logic [31:0] exp, input string tag);
    int   n;
    logic got;
    reg_req      = 1'b1;
    reg_write_en = wr;
    reg_addr     = idx;
    reg_wdata    = data;
    if (!wr) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    got = 1'b0;
    for (n = 0; n < 8 && !got; n++) begin
      @(posedge ap_clk);
      #1;
      got = reg_ack;
    end
    chk({tag, "_ack_lat"}, n, 1);
    if (!wr && exp_q.size() > 0) begin
      if (got) chk(tag_q.pop_front(), reg_rdata, exp_q.pop_front());
      else begin
        void'(tag_q.pop_front());
        void'(exp_q.pop_front());
      end
    end
    reg_req      = 1'b0;
    reg_write_en = 1'b0;
    reg_wdata    = '0;
    @(posedge ap_clk);
    #1;
    chk({tag, "_ack_pulse"}, {reg_ack, reg_rdata}, 0);
  endtask

  task automatic wait_sig(input int sel, input logic val, input string tag);
    logic s;
    s = ~val;
    for (int n = 0; n < 20; n++) begin
      @(negedge ap_clk);
      s = (sel == 0) ? go_0r : (sel == 1) ? done_0a : ap_interrupt;
      if (s == val) break;
    end
    chk(tag, s, val);
  endtask

  task automatic go_hs(input string tag);
    wait_sig(0, 1'b1, {tag, "_go_hi"});
    go_0a = 1'b1;
    wait_sig(0, 1'b0, {tag, "_go_lo"});
    go_0a = 1'b0;
  endtask

  task automatic done_hs(input string tag);
    done_0r = 1'b1;
    wait_sig(1, 1'b1, {tag, "_done_hi"});
    done_0r = 1'b0;
    wait_sig(1, 1'b0, {tag, "_done_lo"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    ap_rst_n = 1'b0; reg_req = 1'b0; reg_write_en = 1'b0; reg_addr = '0;
    reg_wdata = '0; go_0a = 1'b0; done_0r = 1'b0;
    repeat (3) @(negedge ap_clk);
    chk("rst_ack", reg_ack, 0);
    chk("rst_rdata", reg_rdata, 0);
    chk("rst_go", go_0r, 0);
    chk("rst_done_0a", done_0a, 0);
    chk("rst_irq", ap_interrupt, 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // Start path
    reg_xfer(1'b0, 2'd0, 0, 32'h4, "t1_rd_idle");
    reg_xfer(1'b1, 2'd0, 32'h1, 0, "t1_wr_start");
    chk("t1_go_next_cycle", go_0r, 1);
    repeat (5) @(negedge ap_clk);
    chk("t1_go_hold", go_0r, 1);
    go_0a = 1'b1;
    wait_sig(0, 1'b0, "t1_go_fall");
    reg_xfer(1'b0, 2'd0, 0, 32'h8, "t1_rd_ready");
    go_0a = 1'b0;
    done_hs("t1");
    reg_xfer(1'b0, 2'd0, 0, 32'h6, "t1_rd_done");

    // Completion with interrupt
    reg_xfer(1'b1, 2'd1, 32'h1, 0, "t2_wr_gie");
    reg_xfer(1'b1, 2'd2, 32'h1, 0, "t2_wr_ier");
    reg_xfer(1'b1, 2'd0, 32'h1, 0, "t2_wr_start");
    go_hs("t2");
    reg_xfer(1'b0, 2'd0, 0, 32'h8, "t2_rd_ready");
    done_0r = 1'b1;
    wait_sig(1, 1'b1, "t2_done_0a_hi");
    done_0r = 1'b0;
    repeat (2) @(negedge ap_clk);
    chk("t2_irq_2cyc", ap_interrupt, 1);
    chk("t2_done_0a_lo", done_0a, 0);
    reg_xfer(1'b0, 2'd3, 0, 32'h1, "t2_rd_isr");
    reg_xfer(1'b0, 2'd0, 0, 32'h6, "t2_rd_done");
    reg_xfer(1'b0, 2'd0, 0, 32'h4, "t2_rd_cleared");
    reg_xfer(1'b1, 2'd3, 32'h1, 0, "t2_wr_isr");
    chk("t2_irq_clear", ap_interrupt, 0);

    // Masking
    reg_xfer(1'b1, 2'd2, 32'h0, 0, "t3_wr_ier");
    reg_xfer(1'b1, 2'd0, 32'h1, 0, "t3_wr_start");
    go_hs("t3");
    done_hs("t3");
    reg_xfer(1'b0, 2'd3, 0, 32'h0, "t3_rd_isr_masked");
    chk("t3_irq_masked", ap_interrupt, 0);
    reg_xfer(1'b0, 2'd0, 0, 32'hE, "t3_rd_ctrl");
    reg_xfer(1'b1, 2'd1, 32'h0, 0, "t3_wr_gie0");
    reg_xfer(1'b1, 2'd3, 32'h3, 0, "t3_wr_isr");
    reg_xfer(1'b0, 2'd3, 0, 32'h3, "t3_rd_isr_set");
    repeat (2) @(negedge ap_clk);
    chk("t3_irq_gie0", ap_interrupt, 0);
    reg_xfer(1'b1, 2'd3, 32'h3, 0, "t3_wr_isr_clr");
    reg_xfer(1'b0, 2'd3, 0, 32'h0, "t3_rd_isr_clr");
    reg_xfer(1'b1, 2'd2, 32'hFFFF_FFFF, 0, "t3_wr_ier_all");
    reg_xfer(1'b0, 2'd2, 0, 32'h3, "t3_rd_ier_all");
    reg_xfer(1'b1, 2'd2, 32'h0, 0, "t3_wr_ier0");
    reg_xfer(1'b0, 2'd1, 0, 32'h0, "t3_rd_gie");

    // Collisions
    reg_xfer(1'b1, 2'd0, 32'h1, 0, "t4_wr_start");
    go_hs("t4");
    reg_xfer(1'b0, 2'd0, 0, 32'h8, "t4_rd_ready");
    done_0r = 1'b1;
    wait_sig(1, 1'b1, "t4_done_0a_hi");
    done_0r = 1'b0;
    reg_xfer(1'b0, 2'd0, 0, 32'h0, "t4_rd_collide");
    reg_xfer(1'b0, 2'd0, 0, 32'h6, "t4_rd_done_kept");
    reg_xfer(1'b0, 2'd0, 0, 32'h4, "t4_rd_cleared");
    reg_xfer(1'b1, 2'd0, 32'h1, 0, "t4_wr_start2");
    go_hs("t4b");
    reg_xfer(1'b1, 2'd0, 32'h1, 0, "t4_wr_start_run");
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      if (go_0r) highs++;
    end
    chk("t4_no_second_go", highs, 0);
    reg_xfer(1'b0, 2'd0, 0, 32'h8, "t4_rd_run");
    done_hs("t4b");
    reg_xfer(1'b0, 2'd0, 0, 32'h6, "t4_rd_done2");
    repeat (5) @(negedge ap_clk);
    chk("t4_no_queued_go", go_0r, 0);
    reg_xfer(1'b0, 2'd0, 0, 32'h4, "t4_rd_idle");

    // Reset mid-run
    reg_xfer(1'b1, 2'd1, 32'h1, 0, "t5_wr_gie");
    reg_xfer(1'b1, 2'd2, 32'h3, 0, "t5_wr_ier");
    reg_xfer(1'b1, 2'd0, 32'h1, 0, "t5_wr_start");
    go_hs("t5");
    wait_sig(2, 1'b1, "t5_irq_ready");
    done_0r = 1'b1;
    wait_sig(1, 1'b1, "t5_done_0a_hi");
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("t5_rst_done_0a", done_0a, 0);
    chk("t5_rst_go", go_0r, 0);
    chk("t5_rst_irq", ap_interrupt, 0);
    done_0r = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    reg_xfer(1'b0, 2'd0, 0, 32'h4, "t5_rd_ctrl");
    reg_xfer(1'b0, 2'd3, 0, 32'h0, "t5_rd_isr");
    reg_xfer(1'b0, 2'd1, 0, 32'h0, "t5_rd_gie");
    reg_xfer(1'b0, 2'd2, 0, 32'h0, "t5_rd_ier");
    chk("t5_done_0a_idle", done_0a, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
